dmem_responder: RTL and testbench

Data-memory responder for the pipeline core's load/store port: it sits at the other end of the core's memory-stage request channel and answers each request through a valid/ready request and response handshake. The block holds a word-addressed, byte-writable RAM and inserts a programmable number of wait states before each access. Each request gets exactly one response. Misaligned and out-of-range requests are rejected with an error flag and have no side effects.

---
 rtl/dmem_responder.sv | 156 +++++++++++++++
 tb/tb_dmem_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for the core's load/store port.
// Accepts one request at a time over a valid/ready channel, waits a fixed
// number of cycles, performs a byte-writable word access and returns one
// registered response. Misaligned or out-of-range requests return an error
// and leave the RAM untouched.
module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  // A request is rejected when it is not word aligned or lies beyond the RAM.
  function automatic logic addr_err_f(input logic [31:0] a);
    return (a[1:0] != 2'd0) || ((a >> (ADDR_WIDTH + 2)) != 32'd0);
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] word_idx_s;
  logic                  addr_err_s;
  logic                  access_s;
  logic                  mem_we_s;

  assign word_idx_s = addr_q[ADDR_WIDTH+1:2];
  assign addr_err_s = addr_err_f(addr_q);
  assign access_s   = (state_q == ST_BUSY) && (cnt_q == 4'd0);
  assign mem_we_s   = access_s && write_q && !addr_err_s;

  // Ready is decoded from state alone; response outputs come straight from flops.
  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // Next-state, request latch and response computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          wstrb_d = req_wstrb;
          cnt_d   = WAIT_INIT;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          if (addr_err_s) begin
            rsp_rdata_d = 32'd0;
            rsp_err_d   = 1'b1;
          end else if (write_q) begin
            rsp_rdata_d = 32'd0;
            rsp_err_d   = 1'b0;
          end else begin
            rsp_rdata_d = mem[word_idx_s];
            rsp_err_d   = 1'b0;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Control and response registers; reset discards any latched request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-lane RAM write on the access edge; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we_s && wstrb_q[i]) begin
        mem[word_idx_s][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and
// one with zero wait states sharing clock and reset.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic [3:0]  req_wstrb = 4'd0;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid = 1'b0, z_req_ready, z_req_write = 1'b0;
  logic [31:0] z_req_addr = 32'd0, z_req_wdata = 32'd0;
  logic [3:0]  z_req_wstrb = 4'd0;
  logic        z_rsp_valid, z_rsp_ready = 1'b1, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_wstrb(z_req_wstrb),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
    .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the two-wait-state instance. With hold > 0 the
  // response is back-pressured for hold cycles while a conflicting store
  // is offered that must not be accepted.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] er, input logic ee,
                      input int hold, input string tag);
    int n;
    @(negedge clk);
    chk({31'd0, req_ready}, 32'd1, {tag, "_ready"});
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    rsp_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = ~w; req_addr = $urandom;
    req_wdata = $urandom; req_wstrb = 4'hF;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk(32'(n), 32'd3, {tag, "_lat"});
    chk(rsp_rdata, er, {tag, "_rdata"});
    chk({31'd0, rsp_err}, {31'd0, ee}, {tag, "_err"});
    if (hold > 0) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = a;
      req_wdata = 32'hBAD0BAD0; req_wstrb = 4'hF;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        @(negedge clk);
        chk({31'd0, rsp_valid}, 32'd1, {tag, "_hold_valid"});
        chk(rsp_rdata, er, {tag, "_hold_rdata"});
        chk({31'd0, rsp_err}, {31'd0, ee}, {tag, "_hold_err"});
        chk({31'd0, req_ready}, 32'd0, {tag, "_hold_ready"});
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk({31'd0, rsp_valid}, 32'd0, {tag, "_done_valid"});
    chk({31'd0, req_ready}, 32'd1, {tag, "_done_ready"});
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk({31'd0, req_ready}, 32'd1, "rst_ready");
    chk({31'd0, rsp_valid}, 32'd0, "rst_valid");
    chk(rsp_rdata, 32'd0, "rst_rdata");
    chk({31'd0, rsp_err}, 32'd0, "rst_err");
    rst = 1'b1;

    // Known contents for later checks
    xact(1'b1, 32'h0,  32'hCAFEF00D, 4'hF, 32'd0, 1'b0, 0, "init0");
    xact(1'b1, 32'h30, 32'h0,        4'hF, 32'd0, 1'b0, 0, "init30");

    // Basic store then load
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'd0,        1'b0, 0, "st10");
    xact(1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0, 0, "ld10");

    // Partial write and empty strobe
    xact(1'b1, 32'h20, 32'h11223344, 4'hF,    32'd0,        1'b0, 0, "st20");
    xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'd0,        1'b0, 0, "st20p");
    xact(1'b0, 32'h20, 32'h0,        4'h0,    32'h11BB33DD, 1'b0, 0, "ld20p");
    xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0,    32'd0,        1'b0, 0, "st20z");
    xact(1'b0, 32'h20, 32'h0,        4'h0,    32'h11BB33DD, 1'b0, 0, "ld20z");

    // Highest in-range word
    xact(1'b1, 32'hFFC, 32'hA5A5A5A5, 4'hF, 32'd0,        1'b0, 0, "stffc");
    xact(1'b0, 32'hFFC, 32'h0,        4'h0, 32'hA5A5A5A5, 1'b0, 0, "ldffc");

    // Errors: misaligned, out of range; RAM must be untouched
    xact(1'b0, 32'h22,       32'h0,        4'h0, 32'd0, 1'b1, 0, "ld22");
    xact(1'b1, 32'h1000,     32'h12345678, 4'hF, 32'd0, 1'b1, 0, "st1000");
    xact(1'b1, 32'h1,        32'h87654321, 4'hF, 32'd0, 1'b1, 0, "st01");
    xact(1'b0, 32'h80000000, 32'h0,        4'h0, 32'd0, 1'b1, 0, "ldtop");
    xact(1'b0, 32'h0,        32'h0,        4'h0, 32'hCAFEF00D, 1'b0, 0, "ld0");

    // Backpressure, then confirm the offered store was never taken
    xact(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 5, "bp");
    xact(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 0, "ld10b");

    // Reset one cycle after accepting a store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30;
    req_wdata = 32'h55; req_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk({31'd0, rsp_valid}, 32'd0, "mrst_valid");
    chk({31'd0, req_ready}, 32'd1, "mrst_ready");
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk({31'd0, rsp_valid}, 32'd0, "mrst_noresp");
    xact(1'b0, 32'h30, 32'h0, 4'h0, 32'h0, 1'b0, 0, "ld30");

    // Zero wait states, response always accepted, back-to-back requests
    @(negedge clk);
    chk({31'd0, z_req_ready}, 32'd1, "z_ready0");
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h4;
    z_req_wdata = 32'h13579BDF; z_req_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    chk({31'd0, z_req_ready}, 32'd0, "z_st_busy_ready");
    chk({31'd0, z_rsp_valid}, 32'd0, "z_st_busy_valid");
    z_req_write = 1'b0; z_req_wdata = 32'd0;
    @(posedge clk);
    @(negedge clk);
    chk({31'd0, z_rsp_valid}, 32'd1, "z_st_valid");
    chk(z_rsp_rdata, 32'd0, "z_st_rdata");
    chk({31'd0, z_rsp_err}, 32'd0, "z_st_err");
    @(posedge clk);
    @(negedge clk);
    chk({31'd0, z_rsp_valid}, 32'd0, "z_st_done_valid");
    chk({31'd0, z_req_ready}, 32'd1, "z_st_done_ready");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk({31'd0, z_req_ready}, 32'd0, "z_ld_busy_ready");
      chk({31'd0, z_rsp_valid}, 32'd0, "z_ld_busy_valid");
      @(posedge clk);
      @(negedge clk);
      chk({31'd0, z_rsp_valid}, 32'd1, "z_ld_valid");
      chk(z_rsp_rdata, 32'h13579BDF, "z_ld_rdata");
      chk({31'd0, z_rsp_err}, 32'd0, "z_ld_err");
      if (k == 2) z_req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({31'd0, z_rsp_valid}, 32'd0, "z_ld_done_valid");
      chk({31'd0, z_req_ready}, 32'd1, "z_ld_done_ready");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
